// File: rtl/eight_bit_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_isa_pkg
// Description : Shared ISA definitions for the eight-bit CPU (opcodes,
//               register indices, instruction field positions, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package eight_bit_isa_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_SQA = 4'b0110;
    localparam logic [3:0] OP_SQB = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1000;
    localparam logic [3:0] OP_LDA = 4'b1001;
    localparam logic [3:0] OP_LDB = 4'b1010;
    localparam logic [3:0] OP_OUT = 4'b1011;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int FA_MSB = 3;
    localparam int FA_LSB = 2;
    localparam int FB_MSB = 1;
    localparam int FB_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/eight_bit_alu.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_alu
// Description : Combinational execute unit; computes the write-back value and
//               target for one decoded instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module eight_bit_alu
    import eight_bit_isa_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] result,
    output logic              wr_en,
    output logic              wr_b,
    output logic              div_zero,
    output logic              illegal
);

    always_comb begin
        result   = '0;
        wr_en    = 1'b1;
        wr_b     = 1'b0;
        div_zero = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD: result = ra + rb;
            OP_SUB: result = ra - rb;
            OP_MUL: result = ra * rb;
            OP_DIV: begin
                if (rb == '0) begin
                    result   = '1;
                    div_zero = 1'b1;
                end else begin
                    result = ra / rb;
                end
            end
            OP_SHL: result = ra << 1;
            OP_SHR: result = ra >> 1;
            OP_SQA: result = ra * ra;
            OP_SQB: begin
                result = rb * rb;
                wr_b   = 1'b1;
            end
            OP_MOV: result = rb;
            OP_LDA: result = in_a;
            OP_LDB: result = in_b;
            OP_OUT: wr_en = 1'b0;
            default: begin
                wr_en   = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/eight_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_sequencer
// Description : Fetch/execute controller driving the instruction ROM and
//               executing against a 4x8 register file.
// Revision    : 1.0 - initial release
// ============================================================================
module eight_bit_sequencer
    import eight_bit_isa_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        prog_sel,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [7:0]        instruction,
    output logic [1:0]        prog,
    output logic [PC_W-1:0]   address,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    seq_state_t        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [1:0]        r_prog;
    logic [7:0]        r_ir;
    logic [DATA_W-1:0] r_regs [4];
    logic              r_err;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic [3:0]        w_opcode;
    logic [1:0]        w_fa;
    logic [1:0]        w_fb;
    logic [DATA_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rb;
    logic [DATA_W-1:0] w_result;
    logic              w_wr_en;
    logic              w_wr_b;
    logic              w_div_zero;
    logic              w_illegal;

    assign w_opcode = r_ir[OP_MSB:OP_LSB];
    assign w_fa     = r_ir[FA_MSB:FA_LSB];
    assign w_fb     = r_ir[FB_MSB:FB_LSB];
    assign w_ra     = r_regs[w_fa];
    assign w_rb     = r_regs[w_fb];

    eight_bit_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode   (w_opcode),
        .ra       (w_ra),
        .rb       (w_rb),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (w_result),
        .wr_en    (w_wr_en),
        .wr_b     (w_wr_b),
        .div_zero (w_div_zero),
        .illegal  (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_prog      <= '0;
            r_ir        <= '0;
            r_err       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    // Register file deliberately survives a restart.
                    if (start) begin
                        r_pc       <= '0;
                        r_prog     <= prog_sel;
                        r_err      <= 1'b0;
                        r_out_data <= '0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= instruction;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (w_opcode == OP_OUT) begin
                        r_out_data  <= w_ra;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HALT;
                    end else begin
                        if (w_wr_en) begin
                            r_regs[w_wr_b ? w_fb : w_fa] <= w_result;
                        end
                        if (w_div_zero) begin
                            r_err <= 1'b1;
                        end
                        // Running off the end of ROM is an error, never a wrap.
                        if (r_pc == '1) begin
                            r_err   <= 1'b1;
                            r_state <= ST_HALT;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign prog      = r_prog;
    assign address   = r_pc;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign done      = (r_state == ST_HALT);
    assign err       = r_err;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eight_bit_sequencer
// Description : Directed self-checking bench for eight_bit_sequencer with a
//               behavioural ROM (two fixed programs or a bench-filled table).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eight_bit_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] prog_sel;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] instruction;
    logic [1:0] prog;
    logic [7:0] address;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] out_data;
    logic       out_valid;

    logic       use_rom;
    logic [7:0] imem [256];

    int n_checks;
    int n_errors;
    int cyc;
    int ovs;

    eight_bit_sequencer #(
        .PC_W   (8),
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .prog_sel    (prog_sel),
        .in_a        (in_a),
        .in_b        (in_b),
        .instruction (instruction),
        .prog        (prog),
        .address     (address),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .out_data    (out_data),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program 0: lda r0; ldb r1; mul r0,r1; shl r0; out r0. Program 1: lda r0; out r0.
    function automatic logic [7:0] rom(input logic [1:0] p, input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (p == 2'd0) begin
            case (a)
                8'd0: v = 8'h90;
                8'd1: v = 8'hA4;
                8'd2: v = 8'h21;
                8'd3: v = 8'h40;
                8'd4: v = 8'hB0;
                default: v = 8'h00;
            endcase
        end else if (p == 2'd1) begin
            case (a)
                8'd0: v = 8'h90;
                8'd1: v = 8'hB0;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    always_comb instruction = use_rom ? rom(prog, address) : imem[address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] p);
        @(negedge clk);
        prog_sel = p;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(output int c, output int o);
        c = 0;
        o = 0;
        while (!done && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
            if (out_valid) o++;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prog"},  {30'd0, prog}, 32'd0);
        check({tag, "_addr"},  {24'd0, address}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_err"},   {31'd0, err}, 32'd0);
        check({tag, "_odata"}, {24'd0, out_data}, 32'd0);
        check({tag, "_oval"},  {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        prog_sel = 2'd0;
        in_a     = 8'd0;
        in_b     = 8'd0;
        use_rom  = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Program 0: (3*5)<<1 = 0x1E, out is instruction 4 -> edge k+10.
        in_a = 8'd3;
        in_b = 8'd5;
        do_start(2'd0);
        check("p0_addr0", {24'd0, address}, 32'd0);
        check("p0_busy", {31'd0, busy}, 32'd1);
        run_to_done(cyc, ovs);
        check("p0_cycles", cyc, 32'd10);
        check("p0_ovs", ovs, 32'd1);
        check("p0_odata", {24'd0, out_data}, 32'h1E);
        check("p0_err", {31'd0, err}, 32'd0);
        check("p0_addr_end", {24'd0, address}, 32'd4);
        @(posedge clk);
        #1;
        check("p0_pulse_end", {31'd0, out_valid}, 32'd0);
        check("p0_done_hold", {31'd0, done}, 32'd1);
        check("p0_busy_halt", {31'd0, busy}, 32'd0);

        // Program 1: lda r0 with 0xA7, out at edge k+4.
        in_a = 8'hA7;
        do_start(2'd1);
        check("p1_prog", {30'd0, prog}, 32'd1);
        run_to_done(cyc, ovs);
        check("p1_cycles", cyc, 32'd4);
        check("p1_ovs", ovs, 32'd1);
        check("p1_odata", {24'd0, out_data}, 32'hA7);

        // Divide by zero: lda r0(7), ldb r1(0), div r0,r1, out r0.
        use_rom = 1'b0;
        imem[0] = 8'h90;
        imem[1] = 8'hA4;
        imem[2] = 8'h31;
        imem[3] = 8'hB0;
        in_a = 8'd7;
        in_b = 8'd0;
        do_start(2'd2);
        run_to_done(cyc, ovs);
        check("dz_cycles", cyc, 32'd8);
        check("dz_odata", {24'd0, out_data}, 32'hFF);
        check("dz_err", {31'd0, err}, 32'd1);
        check("dz_ovs", ovs, 32'd1);

        // Illegal opcode 1110 at address 0.
        imem[0] = 8'hE0;
        do_start(2'd0);
        run_to_done(cyc, ovs);
        check("ill_cycles", cyc, 32'd2);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_ovs", ovs, 32'd0);
        check("ill_addr", {24'd0, address}, 32'd0);
        check("ill_odata", {24'd0, out_data}, 32'd0);

        // start while busy is ignored; reset during EXEC of instruction 2.
        use_rom = 1'b1;
        in_a = 8'd3;
        in_b = 8'd5;
        do_start(2'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bsy_addr1", {24'd0, address}, 32'd1);
        @(negedge clk);
        prog_sel = 2'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("bsy_prog", {30'd0, prog}, 32'd0);
        check("bsy_addr", {24'd0, address}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("bsy_addr2", {24'd0, address}, 32'd2);
        check("bsy_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("amid");
        @(negedge clk);
        rst_n = 1'b1;
        ovs = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ovs++;
        end
        check("amid_no_ov", ovs, 32'd0);
        check("amid_idle", {31'd0, busy}, 32'd0);
        do_start(2'd0);
        check("rerun_addr0", {24'd0, address}, 32'd0);
        run_to_done(cyc, ovs);
        check("rerun_cycles", cyc, 32'd10);
        check("rerun_odata", {24'd0, out_data}, 32'h1E);

        // add r0,r0 everywhere: runs off the end of ROM.
        use_rom = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        do_start(2'd0);
        run_to_done(cyc, ovs);
        check("end_cycles", cyc, 32'd512);
        check("end_addr", {24'd0, address}, 32'd255);
        check("end_err", {31'd0, err}, 32'd1);
        check("end_ovs", ovs, 32'd0);
        @(posedge clk);
        #1;
        check("end_addr_hold", {24'd0, address}, 32'd255);
        check("end_done_hold", {31'd0, done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
